// File: rtl/imm_encoder.sv
// Iterative search for a rotated-immediate encoding {rot, imm8} of a 32-bit constant.
// Define IMM_ENC_DUAL_EN to test two rotations per search cycle (half the latency).
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [31:0] ValueE,
  input  logic        FlushE,
  output logic        BusyE,
  output logic        DoneE,
  output logic        FoundE,
  output logic [11:0] Imm12E,
  output logic [4:0]  CyclesE
);

  localparam int unsigned VW = 32;
  localparam int unsigned IW = 12;
  localparam int unsigned CW = 5;
  localparam int unsigned RW = 4;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t        state_q, next_state;
  logic [VW-1:0] val_q, val_d;
  logic [RW-1:0] rot_q, rot_d;
  logic          busy_d, done_d, found_d;
  logic [IW-1:0] imm_d;
  logic [CW-1:0] cyc_d;

  logic          hit, last;
  logic [IW-1:0] hit_imm;
  logic [CW-1:0] hit_cyc, miss_cyc;
  logic [RW-1:0] rot_step;
  logic [VW-1:0] cand0;

  // Rotate left by 2*r via a doubled word, avoiding a shift-by-width corner case.
  function automatic logic [VW-1:0] rol2(input logic [VW-1:0] v, input logic [RW-1:0] r);
    logic [2*VW-1:0] d;
    d = {v, v} << {r, 1'b0};
    return d[2*VW-1:VW];
  endfunction

  assign cand0 = rol2(val_q, rot_q);

`ifdef IMM_ENC_DUAL_EN
  logic [RW-1:0] rot1;
  logic [VW-1:0] cand1;
  logic          hit0, hit1;

  assign rot1     = RW'(rot_q + RW'(1));
  assign cand1    = rol2(val_q, rot1);
  assign hit0     = (cand0[VW-1:8] == '0);
  assign hit1     = (cand1[VW-1:8] == '0);
  assign hit      = hit0 | hit1;
  // Lower rotation wins to keep the encoding canonical.
  assign hit_imm  = hit0 ? {rot_q, cand0[7:0]} : {rot1, cand1[7:0]};
  assign hit_cyc  = CW'(CW'(rot_q >> 1) + CW'(1));
  assign last     = (rot_q == RW'(14));
  assign miss_cyc = CW'(8);
  assign rot_step = RW'(2);
`else
  assign hit      = (cand0[VW-1:8] == '0);
  assign hit_imm  = {rot_q, cand0[7:0]};
  assign hit_cyc  = CW'(CW'(rot_q) + CW'(1));
  assign last     = (rot_q == RW'(15));
  assign miss_cyc = CW'(16);
  assign rot_step = RW'(1);
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      rot_q   <= '0;
      BusyE   <= 1'b0;
      DoneE   <= 1'b0;
      FoundE  <= 1'b0;
      Imm12E  <= '0;
      CyclesE <= '0;
    end else begin
      state_q <= next_state;
      val_q   <= val_d;
      rot_q   <= rot_d;
      BusyE   <= busy_d;
      DoneE   <= done_d;
      FoundE  <= found_d;
      Imm12E  <= imm_d;
      CyclesE <= cyc_d;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      IDLE, DONE: next_state = (StartE && !FlushE) ? SEARCH : IDLE;
      SEARCH: begin
        if (FlushE)           next_state = IDLE;
        else if (hit || last) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    val_d   = val_q;
    rot_d   = rot_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    found_d = FoundE;
    imm_d   = Imm12E;
    cyc_d   = CyclesE;
    unique case (state_q)
      IDLE, DONE: begin
        if (StartE && !FlushE) begin
          val_d  = ValueE;
          rot_d  = '0;
          cyc_d  = '0;
          busy_d = 1'b1;
        end
      end
      SEARCH: begin
        if (!FlushE) begin
          if (hit) begin
            found_d = 1'b1;
            imm_d   = hit_imm;
            cyc_d   = hit_cyc;
            done_d  = 1'b1;
          end else if (last) begin
            found_d = 1'b0;
            imm_d   = '0;
            cyc_d   = miss_cyc;
            done_d  = 1'b1;
          end else begin
            rot_d  = RW'(rot_q + rot_step);
            busy_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder (serial or IMM_ENC_DUAL_EN build).
module tb_imm_encoder;

  logic        clk, reset, StartE, FlushE;
  logic [31:0] ValueE;
  logic        BusyE, DoneE, FoundE;
  logic [11:0] Imm12E;
  logic [4:0]  CyclesE;

  int checks = 0;
  int errors = 0;

`ifdef IMM_ENC_DUAL_EN
  localparam int C_F00F = 2, C_FF00 = 3, C_MISS = 8;
`else
  localparam int C_F00F = 3, C_FF00 = 5, C_MISS = 16;
`endif

  imm_encoder dut (
    .clk(clk), .reset(reset), .StartE(StartE), .ValueE(ValueE), .FlushE(FlushE),
    .BusyE(BusyE), .DoneE(DoneE), .FoundE(FoundE), .Imm12E(Imm12E), .CyclesE(CyclesE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; request is accepted at the next edge (E0).
  task automatic start_req(input logic [31:0] v);
    StartE = 1'b1;
    ValueE = v;
    @(posedge clk); #1;
    StartE = 1'b0;
    check("busy_after_start", 32'(BusyE), 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic exp_found,
                           input logic [11:0] exp_imm, input int exp_cyc);
    int n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (DoneE) begin
        n = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_cyc));
    check({tag, "_found"}, 32'(FoundE), 32'(exp_found));
    check({tag, "_imm12"}, 32'(Imm12E), 32'(exp_imm));
    check({tag, "_cycles"}, 32'(CyclesE), 32'(exp_cyc));
    check({tag, "_busy"}, 32'(BusyE), 32'd0);
  endtask

  task automatic quiet(input string tag, input int ncyc);
    int pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (DoneE) pulses++;
    end
    check({tag, "_no_done"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    reset = 1'b1; StartE = 1'b0; FlushE = 1'b0; ValueE = '0;
    #2 reset = 1'b0;
    #2;
    check("rst_busy", 32'(BusyE), 32'd0);
    check("rst_done", 32'(DoneE), 32'd0);
    check("rst_found", 32'(FoundE), 32'd0);
    check("rst_imm12", 32'(Imm12E), 32'd0);
    check("rst_cycles", 32'(CyclesE), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    start_req(32'h0000_00FF);
    wait_done("ff", 1'b1, 12'h0FF, 1);
    @(posedge clk); #1;
    check("ff_done_one_cycle", 32'(DoneE), 32'd0);
    check("ff_held_imm12", 32'(Imm12E), 32'h0FF);

    start_req(32'h0000_0000);
    wait_done("zero", 1'b1, 12'h000, 1);

    start_req(32'hF000_000F);
    wait_done("f00f", 1'b1, 12'h2FF, C_F00F);

    start_req(32'hFF00_0000);
    wait_done("ff00", 1'b1, 12'h4FF, C_FF00);

    start_req(32'h0000_0102);
    wait_done("miss", 1'b0, 12'h000, C_MISS);
    quiet("miss", 4);

    // Flush mid-search while StartE is held with a value that would match instantly.
    start_req(32'h0000_00FF);
    wait_done("pre", 1'b1, 12'h0FF, 1);
    start_req(32'h0000_0102);
    StartE = 1'b1;
    ValueE = 32'h0000_00FF;
    repeat (3) @(posedge clk);
    #1;
    check("hold_start_busy", 32'(BusyE), 32'd1);
    check("hold_start_nodone", 32'(DoneE), 32'd0);
    FlushE = 1'b1;
    @(posedge clk); #1;
    FlushE = 1'b0;
    StartE = 1'b0;
    check("flush_busy", 32'(BusyE), 32'd0);
    check("flush_done", 32'(DoneE), 32'd0);
    check("flush_found", 32'(FoundE), 32'd1);
    check("flush_imm12", 32'(Imm12E), 32'h0FF);
    quiet("flush", 20);
    check("flush_idle_busy", 32'(BusyE), 32'd0);

    // Asynchronous reset between edges during a search.
    start_req(32'h0000_0102);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(BusyE), 32'd0);
    check("arst_done", 32'(DoneE), 32'd0);
    check("arst_found", 32'(FoundE), 32'd0);
    check("arst_imm12", 32'(Imm12E), 32'd0);
    check("arst_cycles", 32'(CyclesE), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    quiet("arst", 20);

    // Back-to-back: restart directly from DONE.
    start_req(32'hF000_000F);
    wait_done("b2b_a", 1'b1, 12'h2FF, C_F00F);
    start_req(32'hFF00_0000);
    wait_done("b2b_b", 1'b1, 12'h4FF, C_FF00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
